multi_port_distributed_ram: RTL
===============================

// Module: multi_port_distributed_ram
// PURPOSE
//  LUT-based (distributed) RAM, generalised to PORTS independent read/write ports
//  with per-byte write strobes. Deterministic write-collision resolution and flag.
//  Optional clear-on-reset sequencer with a ready flag.
//  Shared data/instruction memory behind the RISC-V core plus its debug/loader ports.
// PARAMETERS
//  W              32            word width in bits; must be a multiple of 8 (elab-time $error otherwise)
//  L              128           depth in words; any value >= 2, need not be a power of 2
//  PORTS          2             number of ports, 1..8
//  INIT           "zeros.memh"  $readmemh file loaded at time zero
//  CLEAR_ON_RESET 1             1: zero whole array after rst; 0: rst leaves contents untouched
// PORTS  (A = $clog2(L); port p occupies slice [p*X +: X] of each flattened bus)
//  clk       in   1          clock, all state on posedge
//  rst       in   1          synchronous, active-high reset
//  wr_ena    in   PORTS      per-port write enable
//  wr_strb   in   PORTS*W/8  per-port byte-lane write strobes (bit b -> data[8b+7:8b])
//  addr      in   PORTS*A    per-port word address (read and write)
//  wr_data   in   PORTS*W    per-port write data
//  rd_data   out  PORTS*W    per-port read data
//  ready     out  1          1 = array accepts writes; 0 during reset/clear
//  collision out  1          registered pulse: same-address write collision last cycle
// BEHAVIOUR
//  FSM: S_RESET -> S_CLEAR -> S_READY. rst=1 in any state forces S_RESET next cycle.
//   S_RESET: clr_addr<=0; next S_CLEAR if CLEAR_ON_RESET else S_READY.
//   S_CLEAR: writes 0 to ram[clr_addr] each cycle, clr_addr++; after L-1 -> S_READY.
//            Full clear = L cycles after rst deasserts; rst mid-clear restarts at word 0.
//   S_READY: terminal until rst.
//  Reset values: ready=0, collision=0, rd_data=0 (registered mode only).
//  ready=1 iff state==S_READY (registered, no combinational path from inputs).
//  Writes: port p updates byte b of ram[addr_p] iff ready & wr_ena[p] & wr_strb[p][b]
//   & addr_p<L. Writes with ready=0 are dropped silently (no queueing).
//  Out-of-range addr (addr>=L, non-pow2 L): write dropped, read returns 0.
//  Collision: >=2 enabled ports, same in-range addr, overlapping strobes -> per byte
//   lane the HIGHEST port index wins; non-overlapping lanes merge. collision=1 the
//   next cycle for exactly one cycle per colliding cycle (overlap required; disjoint
//   strobes do not flag). Never asserted while ready=0.
//  Read (default): rd_data_p = ram[addr_p] combinational, 0 latency; sensitive to
//   addr AND array contents (new data visible after the write edge). Same-cycle
//   read of a written address returns OLD data (read-first).
//  Reads during S_CLEAR are legal and return current (partly cleared) contents.
//  PORTS=1: collision tied 0.
// CONFIGURATION
//  MPRAM_RD_REG_EN defined: rd_data registered on posedge, 1-cycle latency,
//   read-first (returns pre-write word), rst clears rd_data to 0; maps to LUTRAM+FF.
//  Not defined: combinational read as above, rd_data has no reset value.
//  Collision, strobe, clear and ready behaviour identical in both modes.
// TESTING  (W=32, L=128, PORTS=2 unless noted; run with and without MPRAM_RD_REG_EN)
//  1 rst 1 cycle, CLEAR_ON_RESET=1, INIT all 0xA5A5A5A5 -> ready low exactly 129
//    cycles after rst falls (1 RESET + 128 CLEAR); then all 128 words read 0x00000000.
//  2 rst pulse at clear word 60 -> clear restarts at 0, ready rises 129 cycles after
//    second rst falls; write attempted with ready=0 to addr 5 -> word stays 0.
//  3 p0 writes 0x11223344 strb 4'b1111 to 7, p1 writes 0xAABBCCDD strb 4'b0011
//    to 7 same cycle -> ram[7]=0x1122CCDD, collision=1 next cycle only.
//  4 p0 strb 4'b1100, p1 strb 4'b0011 same addr 9 -> merged word, collision stays 0.
//  5 p0 writes 0xDEADBEEF addr 3 while p1 reads addr 3 same cycle -> p1 sees old
//    value that cycle, 0xDEADBEEF next (default) / one cycle later (RD_REG_EN).
//  6 L=100: write addr 120 -> no array change; read addr 120 -> rd_data=0.

Source files
------------

// File: rtl/multi_port_distributed_ram.sv
// Multi-port LUT RAM with byte strobes, highest-port-wins collision merge and clear-on-reset.
// Define MPRAM_RD_REG_EN for registered (1-cycle) reads; default is combinational read.
module multi_port_distributed_ram #(
  parameter int unsigned W              = 32,
  parameter int unsigned L              = 128,
  parameter int unsigned PORTS          = 2,
  parameter              INIT           = "zeros.memh",
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            wr_ena,
  input  logic [PORTS*W/8-1:0]        wr_strb,
  input  logic [PORTS*$clog2(L)-1:0]  addr,
  input  logic [PORTS*W-1:0]          wr_data,
  output logic [PORTS*W-1:0]          rd_data,
  output logic                        ready,
  output logic                        collision
);

  localparam int unsigned A     = $clog2(L);
  localparam int unsigned NB    = W / 8;
  localparam logic [A:0]  DEPTH = (A+1)'(L);
  localparam logic [A-1:0] LAST = A'(L - 1);

  if (W % 8 != 0) begin : g_bad_width
    $error("multi_port_distributed_ram: W=%0d is not a multiple of 8", W);
  end
  if (PORTS < 1 || PORTS > 8 || L < 2) begin : g_bad_shape
    $error("multi_port_distributed_ram: bad shape PORTS=%0d L=%0d INIT=%s", PORTS, L, INIT);
  end

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [A-1:0]   r_clr_addr;
  logic [W-1:0]   r_mem [L];
  logic [A-1:0]   w_addr [PORTS];
  logic [PORTS-1:0] w_inrange;
  logic [W-1:0]   w_rd [PORTS];
  logic           w_ready;
  logic           w_coll;
  logic           r_coll;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = CLEAR_ON_RESET ? S_CLEAR : S_READY;
      S_CLEAR: if (r_clr_addr == LAST) w_next = S_READY;
      S_READY: w_next = S_READY;
      default: w_next = S_RESET;
    endcase
  end

  always_comb begin
    w_ready   = (r_state == S_READY);
    ready     = w_ready;
    collision = r_coll;
  end

  always_ff @(posedge clk) begin
    if (r_state == S_RESET)      r_clr_addr <= '0;
    else if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + A'(1);
  end

  always_comb begin
    w_addr    = '{default: '0};
    w_inrange = '0;
    w_rd      = '{default: '0};
    for (int unsigned p = 0; p < PORTS; p++) begin
      w_addr[p]    = addr[p*A +: A];
      w_inrange[p] = ({1'b0, w_addr[p]} < DEPTH);
      w_rd[p]      = w_inrange[p] ? r_mem[w_addr[p]] : '0;
    end
  end

  // A collision needs a shared in-range word and at least one shared byte lane.
  always_comb begin
    w_coll = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      for (int unsigned j = i + 1; j < PORTS; j++) begin
        if (w_ready && wr_ena[i] && wr_ena[j] && w_inrange[i] &&
            (w_addr[i] == w_addr[j]) &&
            ((wr_strb[i*NB +: NB] & wr_strb[j*NB +: NB]) != '0))
          w_coll = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_coll <= 1'b0;
    else     r_coll <= w_coll;
  end

  // Ascending port order: the last NBA to a lane wins, so the highest port index takes it.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_ready) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (wr_ena[p] && wr_strb[p*NB + b] && w_inrange[p])
            r_mem[w_addr[p]][8*b +: 8] <= wr_data[p*W + 8*b +: 8];
        end
      end
    end
  end

`ifdef MPRAM_RD_REG_EN
  logic [PORTS*W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      for (int unsigned p = 0; p < PORTS; p++) r_rd_data[p*W +: W] <= w_rd[p];
    end
  end

  always_comb rd_data = r_rd_data;
`else
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < PORTS; p++) rd_data[p*W +: W] = w_rd[p];
  end
`endif

endmodule
